des_iter_core: RTL and testbench



---
 rtl/des_iter_core.sv | 256 +++++++++++++++++++++++++
 tb/tb_des_iter_core.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES engine, ROUNDS_PER_CYCLE Feistel rounds
// per clock, round keys derived on the fly from rotating C/D halves.
module des_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_text,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_text,
  output logic        out_decrypt,
  output logic        busy
);
  localparam int ITER =
    (ROUNDS_PER_CYCLE > 0) ? 16 / ROUNDS_PER_CYCLE : 0;
  localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

  if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > 16 ||
      ITER * ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};

  // One 64-nibble row-major table per S-box, index {outer, inner}
  localparam logic [255:0] S_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return o;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return o;
  endfunction

  function automatic logic [3:0] sbox(
    input logic [2:0] n,
    input logic [5:0] x
  );
    logic [5:0]   k;
    logic [255:0] t;
    k = {x[5], x[0], x[4:1]};
    t = S_T[n] >> {~k, 2'b00};
    return t[3:0];
  endfunction

  function automatic logic [31:0] feistel(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[i])];
    x = x ^ k;
    for (int i = 0; i < 8; i++)
      s[5'(31 - 4 * i) -: 4] = sbox(3'(i), x[6'(47 - 6 * i) -: 6]);
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - P_T[i])];
    return o;
  endfunction

  function automatic logic [1:0] shamt(input logic [4:0] i);
    return (i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16) ?
      2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rol28(
    input logic [27:0] x,
    input logic [1:0]  s
  );
    return (s == 2'd2) ? {x[25:0], x[27:26]} :
           (s == 2'd1) ? {x[26:0], x[27]} : x;
  endfunction

  function automatic logic [27:0] ror28(
    input logic [27:0] x,
    input logic [1:0]  s
  );
    return (s == 2'd2) ? {x[1:0], x[27:2]} :
           (s == 2'd1) ? {x[0], x[27:1]} : x;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [4:0]  cnt_n;
  logic [31:0] l, r, l_n, r_n, t;
  logic [27:0] c, d, c_n, d_n;
  logic [4:0]  idx;
  logic [1:0]  sh;
  logic [47:0] rk;
  logic        dec;

  assign cnt_n    = cnt + STEP;
  assign in_ready = (state == IDLE);
  assign busy     = (state == ROUND);

  always_comb begin
    l_n = l;
    r_n = r;
    c_n = c;
    d_n = d;
    idx = '0;
    sh  = '0;
    rk  = '0;
    t   = '0;
    for (int j = 1; j <= ROUNDS_PER_CYCLE; j++) begin
      idx = cnt + 5'(j);
      if (!dec) begin
        sh  = shamt(idx);
        c_n = rol28(c_n, sh);
        d_n = rol28(d_n, sh);
      end else begin
        // C0/D0 already equal C16/D16, so decrypt walks backwards
        sh  = (idx == 5'd1) ? 2'd0 : shamt(5'd18 - idx);
        c_n = ror28(c_n, sh);
        d_n = ror28(d_n, sh);
      end
      rk  = pc2({c_n, d_n});
      t   = l_n ^ feistel(r_n, rk);
      l_n = r_n;
      r_n = t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      l           <= '0;
      r           <= '0;
      c           <= '0;
      d           <= '0;
      dec         <= 1'b0;
      out_valid   <= 1'b0;
      out_text    <= '0;
      out_decrypt <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            {l, r} <= ip(in_text);
            {c, d} <= pc1(in_key);
            dec    <= in_decrypt;
            cnt    <= '0;
            state  <= ROUND;
          end
        end
        ROUND: begin
          l   <= l_n;
          r   <= r_n;
          c   <= c_n;
          d   <= d_n;
          cnt <= cnt_n;
          if (cnt_n == 5'd16) begin
            out_text    <= fp({r_n, l_n});
            out_decrypt <= dec;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: directed DES vectors, latency for every unroll
// factor, backpressure, async reset and an enc/dec round-trip stream.
module tb_des_iter_core;
  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT2 = 64'h8787878787878787;
  localparam logic [63:0] CT2 = 64'h0000000000000000;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_text;
  logic [63:0] in_key;
  logic        in_decrypt;
  logic        out_ready;
  logic        ir [5];
  logic        ov [5];
  logic        od [5];
  logic        bz [5];
  logic [63:0] ot [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (ir[g]),
      .in_text    (in_text),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .out_valid  (ov[g]),
      .out_ready  (out_ready),
      .out_text   (ot[g]),
      .out_decrypt(od[g]),
      .busy       (bz[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [63:0] key,
    input logic [63:0] text,
    input logic        dec
  );
    int n = 0;
    in_key     = key;
    in_text    = text;
    in_decrypt = dec;
    in_valid   = 1'b1;
    while (ir[0] !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    if (n >= TMO) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", ir[0]);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(
    output logic [63:0] text,
    output logic        dec,
    input  int          delay
  );
    int n = 0;
    repeat (delay) tick();
    while (ov[0] !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    if (n >= TMO) begin
      errors++;
      $display("FAIL recv_timeout: out_valid=%b required 1", ov[0]);
    end
    text = ot[0];
    dec  = od[0];
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_text    = '0;
    in_key     = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b0;
    #3;
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", ir[0]);
    end
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b required 0", ov[0]);
    end
    checks++;
    if (bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", bz[0]);
    end
    checks++;
    if (ot[0] !== 64'h0) begin
      errors++;
      $display("FAIL reset_out_text: got %h required 0", ot[0]);
    end
    checks++;
    if (od[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_decrypt: got %b required 0", od[0]);
    end
    #19;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int lat [5];
    for (int g = 0; g < 5; g++) lat[g] = 0;
    in_key     = K1;
    in_text    = PT1;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      for (int g = 0; g < 5; g++)
        if (ov[g] === 1'b1 && lat[g] == 0) lat[g] = e;
    end
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (lat[g] != (16 >> g)) begin
        errors++;
        $display("FAIL latency_r%0d: got %0d edges required %0d",
                 1 << g, lat[g], 16 >> g);
      end
      checks++;
      if (ot[g] !== CT1) begin
        errors++;
        $display("FAIL enc_v1_r%0d: got %h required %h",
                 1 << g, ot[g], CT1);
      end
      checks++;
      if (od[g] !== 1'b0) begin
        errors++;
        $display("FAIL enc_v1_dec_r%0d: got %b required 0",
                 1 << g, od[g]);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_decrypt();
    logic [63:0] t;
    logic        d;
    send(K1, CT1, 1'b1);
    recv(t, d, 0);
    checks++;
    if (t !== PT1) begin
      errors++;
      $display("FAIL dec_v1: got %h required %h", t, PT1);
    end
    checks++;
    if (d !== 1'b1) begin
      errors++;
      $display("FAIL dec_v1_echo: got %b required 1", d);
    end
  endtask

  task automatic test_vector2();
    logic [63:0] t;
    logic        d;
    send(K2, PT2, 1'b0);
    recv(t, d, 2);
    checks++;
    if (t !== CT2 || d !== 1'b0) begin
      errors++;
      $display("FAIL enc_v2: got %h/%b required %h/0", t, d, CT2);
    end
    send(K2, CT2, 1'b1);
    recv(t, d, 0);
    checks++;
    if (t !== PT2 || d !== 1'b1) begin
      errors++;
      $display("FAIL dec_v2: got %h/%b required %h/1", t, d, PT2);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int bad = 0;
    send(K1, PT1, 1'b0);
    checks++;
    if (bz[0] !== 1'b1 || ir[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_round: busy=%b in_ready=%b required 1/0",
               bz[0], ir[0]);
    end
    while (ov[0] !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    in_key     = K2;
    in_text    = PT2;
    in_decrypt = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ot[0] !== CT1 || ov[0] !== 1'b1 ||
          ir[0] !== 1'b0 || od[0] !== 1'b0) begin
        if (bad == 0)
          $display("FAIL bp_hold: cycle %0d text=%h v=%b rdy=%b",
                   i, ot[0], ov[0], ir[0]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1",
               ov[0], ir[0]);
    end
    tick();
    checks++;
    if (bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_take: busy=%b in_ready=%b required 0/1",
               bz[0], ir[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] t;
    logic        d;
    send(K1, PT1, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    checks++;
    if (bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b required 1", bz[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ot[0] !== 64'h0 || ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: text=%h v=%b required 0/0",
               ot[0], ov[0]);
    end
    checks++;
    if (ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: rdy=%b busy=%b required 1/0",
               ir[0], bz[0]);
    end
    #3;
    rst_n = 1'b1;
    tick();
    send(K1, PT1, 1'b0);
    recv(t, d, 1);
    checks++;
    if (t !== CT1 || d !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: got %h/%b required %h/0", t, d, CT1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] key, pt, ct, rt;
    logic        d;
    for (int i = 0; i < 50; i++) begin
      key = {$urandom, $urandom};
      pt  = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) tick();
      send(key, pt, 1'b0);
      recv(ct, d, $urandom_range(0, 4));
      checks++;
      if (d !== 1'b0) begin
        errors++;
        $display("FAIL b2b_enc_echo[%0d]: got %b required 0", i, d);
      end
      repeat ($urandom_range(0, 3)) tick();
      send(key, ct, 1'b1);
      recv(rt, d, $urandom_range(0, 4));
      checks++;
      if (rt !== pt || d !== 1'b1) begin
        errors++;
        $display("FAIL b2b_roundtrip[%0d]: got %h/%b required %h/1",
                 i, rt, d, pt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_decrypt();
    test_vector2();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
